reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 32, meaning the number of entries (power of two, at least 8).
REQ-002 SHALL have parameter IDX_W, default $clog2(ROB_SIZE), meaning the entry index width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port dispatch_valid, input, [2:0]: per-slot dispatch request; bit 2 is the oldest; set bits contiguous from bit 2.
REQ-006 SHALL have port dispatch_entry, input, ROB_ENTRY_PACKET[2:0]: entries to allocate (arch_reg, Tnew, is_store, halt, target_pc); the incoming completed and precise_state_need fields are ignored.
REQ-007 SHALL have port dispatch_idx, output, [2:0][IDX_W-1:0]: the ROB index each dispatch slot receives this cycle.
REQ-008 SHALL have port free_slots, output, [1:0]: min(3, ROB_SIZE - count), from registered state.
REQ-009 SHALL have port complete_valid, input, [2:0]: completion strobes from the three writeback ports.
REQ-010 SHALL have port complete_idx, input, [2:0][IDX_W-1:0]: ROB index of each completing entry.
REQ-011 SHALL have port complete_mispredict, input, [2:0]: the completing instruction needs precise-state recovery.
REQ-012 SHALL have port complete_target_pc, input, [2:0][`XLEN-1:0]: the correct PC when complete_mispredict is set.
REQ-013 SHALL have port rob_head_entry, output, ROB_ENTRY_PACKET[2:0]: the three oldest entries; [2] is the head.
REQ-014 SHALL have port retire_mask, input, [2:0]: retire_valid from the retire stage (its inst_count); contiguous from bit 2.
REQ-015 SHALL have port BPRecoverEN, input, 1 bit: flush request from the retire stage.
REQ-016 SHALL have port rob_empty, output, 1 bit, and port rob_full, output, 1 bit.

Function
REQ-017 SHALL hold head pointer, tail pointer (IDX_W bits each, wrapping modulo ROB_SIZE) and count (IDX_W+1 bits).
REQ-018 SHALL set dispatch_idx[2] = tail, [1] = tail+1 and [0] = tail+2, all modulo ROB_SIZE.
REQ-019 SHALL accept a dispatch group only when popcount(dispatch_valid) <= free_slots; otherwise it SHALL drop the whole group, with no partial allocation.
REQ-020 SHALL write accepted entries with completed=0 and precise_state_need=0, advance tail by the accepted count, and make them visible on rob_head_entry no earlier than the next cycle.
REQ-021 SHALL, for each complete_valid[k], set completed=1 at complete_idx[k]; if complete_mispredict[k], it SHALL also set precise_state_need=1 and target_pc=complete_target_pc[k]. The update is visible the next cycle.
REQ-022 SHALL ignore completion to an index outside the occupied range.
REQ-023 SHALL apply port 2 over port 1 over port 0 when two ports hit the same index (priority).
REQ-024 SHALL drive rob_head_entry[2-j] from storage at head+j when j < count; otherwise that slot SHALL be all-zero, so completed=0.
REQ-025 SHALL advance head by popcount(retire_mask) at the clock edge and decrement count by the same amount.
REQ-026 SHALL compute next count as count + accepted - retired in the same cycle; free_slots SHALL NOT credit same-cycle retirement.
REQ-027 SHALL, when BPRecoverEN=1, first apply that cycle's retire_mask to head, then set tail=new head, count=0 and clear all completed and precise_state_need bits. Same-cycle dispatch and completion SHALL be discarded.
REQ-028 SHALL assert rob_empty when count==0 and rob_full when count==ROB_SIZE, both from registered state.
REQ-029 SHALL handle wrap-around transparently: a group straddling index ROB_SIZE-1 to 0 SHALL behave identically to a non-straddling group.
REQ-030 SHALL treat a retire_mask bit set for an unoccupied slot as illegal; the design SHALL assert in simulation and SHALL NOT change state for that bit.

Reset
REQ-031 SHALL, on reset, set head=0, tail=0, count=0 and clear all completed and precise_state_need bits.
REQ-032 SHALL drive outputs the cycle after reset is asserted as: rob_empty=1, rob_full=0, free_slots=3, dispatch_idx={0,1,2}, rob_head_entry all-zero.
REQ-033 SHALL let reset win over dispatch, completion, retire and BPRecoverEN in the same cycle.

Verification
REQ-034 SHALL cover: reset, dispatch 3 entries, complete idx 0,1,2, retire_mask=3'b111 -> the next cycle head=3, count=0 and rob_empty=1.
REQ-035 SHALL cover: fill to count=30 then dispatch_valid=3'b111 -> group dropped, tail unchanged; dispatch 3'b110 -> accepted, count=32, rob_full=1, free_slots=0.
REQ-036 SHALL cover: head=30, dispatch 3 entries -> dispatch_idx={30,31,0}; after completion, rob_head_entry shows entries 30,31,0 with completed=1.
REQ-037 SHALL cover: complete idx 1 with mispredict and target 32'h100, then retire_mask=3'b110 with BPRecoverEN=1 -> head=2, tail=2, count=0, and a same-cycle dispatch is ignored.
REQ-038 SHALL cover: ports 2 and 0 complete the same index with mispredict targets 32'hA0 and 32'hB0 -> target_pc=32'hA0.
REQ-039 SHALL cover: reset asserted while count=5 and a dispatch is pending -> next cycle count=0, rob_empty=1, rob_head_entry all-zero.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: 3-wide dispatch, 3 completion ports, 3-wide in-order retire,
// precise-state flush driven by the retire stage.

`ifndef XLEN
`define XLEN 32
`endif

package reorder_buffer_pkg;
   typedef struct packed {
      logic [4:0]       arch_reg;
      logic [5:0]       Tnew;
      logic             is_store;
      logic             halt;
      logic [`XLEN-1:0] target_pc;
      logic             completed;
      logic             precise_state_need;
   } ROB_ENTRY_PACKET;
endpackage

module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ROB_SIZE = 32,
   parameter int unsigned IDX_W    = $clog2(ROB_SIZE)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic            [2:0]            dispatch_valid,
   input  ROB_ENTRY_PACKET [2:0]            dispatch_entry,
   output logic            [2:0][IDX_W-1:0] dispatch_idx,
   output logic            [1:0]            free_slots,
   input  logic            [2:0]            complete_valid,
   input  logic            [2:0][IDX_W-1:0] complete_idx,
   input  logic            [2:0]            complete_mispredict,
   input  logic            [2:0][`XLEN-1:0] complete_target_pc,
   output ROB_ENTRY_PACKET [2:0]            rob_head_entry,
   input  logic            [2:0]            retire_mask,
   input  logic                             BPRecoverEN,
   output logic                             rob_empty,
   output logic                             rob_full
);

   ROB_ENTRY_PACKET        mem [ROB_SIZE];
   ROB_ENTRY_PACKET [2:0]  disp_pkt;
   logic [IDX_W-1:0]       head, tail, head_d, tail_d;
   logic [IDX_W:0]         count, count_d, space;
   logic [1:0]             disp_cnt, ret_cnt, ret_raw;
   logic                   accept;
   logic [2:0][IDX_W-1:0]  comp_off;
   logic [2:0]             comp_hit;

   // Capacity, group acceptance and retire count from registered state.
   always_comb begin
      space      = (IDX_W+1)'(ROB_SIZE) - count;
      free_slots = (space >= (IDX_W+1)'(3)) ? 2'd3 : space[1:0];
      disp_cnt   = 2'(dispatch_valid[2]) + 2'(dispatch_valid[1]) + 2'(dispatch_valid[0]);
      accept     = (disp_cnt <= free_slots);
      ret_cnt    = '0;
      ret_raw    = '0;
      // Mask bits past the occupied range are dropped rather than retired.
      for (int j = 0; j < 3; j++) begin
         if (retire_mask[2-j]) begin
            ret_raw = ret_raw + 2'd1;
            if ((IDX_W+1)'(j) < count) ret_cnt = ret_cnt + 2'd1;
         end
      end
   end

   // Next-state pointers and occupancy; a flush collapses tail onto the new head.
   always_comb begin
      head_d = head + IDX_W'(ret_cnt);
      if (BPRecoverEN) begin
         tail_d  = head_d;
         count_d = '0;
      end else begin
         tail_d  = tail + (accept ? IDX_W'(disp_cnt) : '0);
         count_d = count + (accept ? (IDX_W+1)'(disp_cnt) : '0) - (IDX_W+1)'(ret_cnt);
      end
   end

   // Completion hits only count when the index lies inside [head, head+count).
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         comp_off[k] = complete_idx[k] - head;
         comp_hit[k] = ({1'b0, comp_off[k]} < count);
      end
   end

   // Incoming entries always start not-completed, regardless of their flag fields.
   always_comb begin
      for (int s = 0; s < 3; s++) begin
         disp_pkt[s]                    = dispatch_entry[s];
         disp_pkt[s].completed          = 1'b0;
         disp_pkt[s].precise_state_need = 1'b0;
      end
   end

   // Output views: allocation indices from tail, oldest three entries from head.
   always_comb begin
      for (int j = 0; j < 3; j++) begin
         dispatch_idx[2-j]   = tail + IDX_W'(j);
         rob_head_entry[2-j] = ((IDX_W+1)'(j) < count) ? mem[head + IDX_W'(j)] : '0;
      end
      rob_empty = (count == '0);
      rob_full  = (count == (IDX_W+1)'(ROB_SIZE));
   end

   // State update; later completion ports are written last so port 2 wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < ROB_SIZE; i++) mem[i] <= '0;
      end else begin
         head  <= head_d;
         tail  <= tail_d;
         count <= count_d;
         if (BPRecoverEN) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
               mem[i].completed          <= 1'b0;
               mem[i].precise_state_need <= 1'b0;
            end
         end else begin
            if (accept) begin
               for (int s = 0; s < 3; s++) begin
                  if (dispatch_valid[s]) mem[tail + IDX_W'(2 - s)] <= disp_pkt[s];
               end
            end
            for (int k = 0; k < 3; k++) begin
               if (complete_valid[k] && comp_hit[k]) begin
                  mem[complete_idx[k]].completed <= 1'b1;
                  if (complete_mispredict[k]) begin
                     mem[complete_idx[k]].precise_state_need <= 1'b1;
                     mem[complete_idx[k]].target_pc          <= complete_target_pc[k];
                  end
               end
            end
         end
      end
   end

   // Retiring an unoccupied slot is a retire-stage bug.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (ret_cnt == ret_raw);
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed corner cases plus random
// traffic compared every cycle against a queue-level model.

`ifndef XLEN
`define XLEN 32
`endif

module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int N     = 32;
   localparam int IDX_W = 5;

   logic                            clock = 1'b0;
   logic                            reset;
   logic            [2:0]           dispatch_valid;
   ROB_ENTRY_PACKET [2:0]           dispatch_entry;
   logic            [2:0][IDX_W-1:0] dispatch_idx;
   logic            [1:0]           free_slots;
   logic            [2:0]           complete_valid;
   logic            [2:0][IDX_W-1:0] complete_idx;
   logic            [2:0]           complete_mispredict;
   logic            [2:0][`XLEN-1:0] complete_target_pc;
   ROB_ENTRY_PACKET [2:0]           rob_head_entry;
   logic            [2:0]           retire_mask;
   logic                            BPRecoverEN;
   logic                            rob_empty;
   logic                            rob_full;

   reorder_buffer #(.ROB_SIZE(N), .IDX_W(IDX_W)) dut (
      .clock               (clock),
      .reset               (reset),
      .dispatch_valid      (dispatch_valid),
      .dispatch_entry      (dispatch_entry),
      .dispatch_idx        (dispatch_idx),
      .free_slots          (free_slots),
      .complete_valid      (complete_valid),
      .complete_idx        (complete_idx),
      .complete_mispredict (complete_mispredict),
      .complete_target_pc  (complete_target_pc),
      .rob_head_entry      (rob_head_entry),
      .retire_mask         (retire_mask),
      .BPRecoverEN         (BPRecoverEN),
      .rob_empty           (rob_empty),
      .rob_full            (rob_full)
   );

   always #5 clock = ~clock;

   // Model: circular array with head and occupancy, updated by plain arithmetic.
   ROB_ENTRY_PACKET m_mem [N];
   int m_head = 0;
   int m_cnt  = 0;
   int n_vec  = 0;
   int n_err  = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ROB_ENTRY_PACKET rand_entry();
      ROB_ENTRY_PACKET e;
      e.arch_reg           = 5'($urandom);
      e.Tnew               = 6'($urandom);
      e.is_store           = 1'($urandom);
      e.halt               = 1'($urandom);
      e.target_pc          = `XLEN'($urandom);
      e.completed          = 1'($urandom);
      e.precise_state_need = 1'($urandom);
      return e;
   endfunction

   task automatic clear_inputs();
      reset               = 1'b0;
      dispatch_valid      = '0;
      dispatch_entry      = '0;
      complete_valid      = '0;
      complete_idx        = '0;
      complete_mispredict = '0;
      complete_target_pc  = '0;
      retire_mask         = '0;
      BPRecoverEN         = 1'b0;
   endtask

   task automatic model_step();
      int n, r, fr;
      ROB_ENTRY_PACKET e;
      if (reset) begin
         m_head = 0;
         m_cnt  = 0;
         for (int i = 0; i < N; i++) m_mem[i] = '0;
         return;
      end
      fr = (N - m_cnt < 3) ? N - m_cnt : 3;
      n  = $countones(dispatch_valid);
      r  = $countones(retire_mask);
      if (BPRecoverEN) begin
         m_head = (m_head + r) % N;
         m_cnt  = 0;
         for (int i = 0; i < N; i++) begin
            m_mem[i].completed          = 1'b0;
            m_mem[i].precise_state_need = 1'b0;
         end
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (complete_valid[k] && ((int'(complete_idx[k]) - m_head + N) % N) < m_cnt) begin
            m_mem[complete_idx[k]].completed = 1'b1;
            if (complete_mispredict[k]) begin
               m_mem[complete_idx[k]].precise_state_need = 1'b1;
               m_mem[complete_idx[k]].target_pc          = complete_target_pc[k];
            end
         end
      end
      if (n <= fr) begin
         for (int j = 0; j < n; j++) begin
            e                    = dispatch_entry[2-j];
            e.completed          = 1'b0;
            e.precise_state_need = 1'b0;
            m_mem[(m_head + m_cnt + j) % N] = e;
         end
      end else begin
         n = 0;
      end
      m_head = (m_head + r) % N;
      m_cnt  = m_cnt + n - r;
   endtask

   task automatic compare();
      ROB_ENTRY_PACKET [2:0]  exp_he;
      logic [2:0][IDX_W-1:0]  exp_di;
      int                     fr;
      for (int j = 0; j < 3; j++) begin
         exp_di[2-j] = IDX_W'((m_head + m_cnt + j) % N);
         exp_he[2-j] = (j < m_cnt) ? m_mem[(m_head + j) % N] : '0;
      end
      fr = (N - m_cnt < 3) ? N - m_cnt : 3;
      chk("free_slots", 256'(free_slots), 256'(fr));
      chk("rob_empty", 256'(rob_empty), 256'(m_cnt == 0));
      chk("rob_full", 256'(rob_full), 256'(m_cnt == N));
      chk("dispatch_idx", 256'(dispatch_idx), 256'(exp_di));
      chk("rob_head_entry", 256'(rob_head_entry), 256'(exp_he));
   endtask

   // One clock: model consumes the same inputs the DUT sees at the edge.
   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      compare();
      clear_inputs();
   endtask

   task automatic disp3();
      dispatch_valid = 3'b111;
      for (int s = 0; s < 3; s++) dispatch_entry[s] = rand_entry();
   endtask

   initial begin
      int r;
      clear_inputs();
      reset = 1'b1;
      disp3();
      cycle();
      chk("rst_free", 256'(free_slots), 256'(3));
      chk("rst_idx2", 256'(dispatch_idx[2]), 256'(0));
      chk("rst_idx0", 256'(dispatch_idx[0]), 256'(2));
      chk("rst_empty", 256'(rob_empty), 256'(1));

      // Dispatch 3, complete 0..2, retire all.
      disp3(); cycle();
      complete_valid = 3'b111;
      complete_idx[2] = 5'd0; complete_idx[1] = 5'd1; complete_idx[0] = 5'd2;
      cycle();
      chk("c_head_done", 256'({rob_head_entry[2].completed, rob_head_entry[0].completed}), 256'(3));
      retire_mask = 3'b111; cycle();
      chk("r_tail3", 256'(dispatch_idx[2]), 256'(3));
      chk("r_empty", 256'(rob_empty), 256'(1));

      // Move head to 30, then straddle the wrap.
      for (int i = 0; i < 9; i++) begin disp3(); cycle(); end
      for (int i = 0; i < 9; i++) begin retire_mask = 3'b111; cycle(); end
      chk("w_idx2", 256'(dispatch_idx[2]), 256'(30));
      chk("w_idx1", 256'(dispatch_idx[1]), 256'(31));
      chk("w_idx0", 256'(dispatch_idx[0]), 256'(0));
      disp3(); cycle();
      complete_valid = 3'b111;
      complete_idx[2] = 5'd30; complete_idx[1] = 5'd31; complete_idx[0] = 5'd0;
      cycle();
      chk("w_done", 256'({rob_head_entry[2].completed, rob_head_entry[1].completed,
                          rob_head_entry[0].completed}), 256'(7));
      retire_mask = 3'b111; cycle();

      // Fill to 30, overflow group dropped, then a 2-wide group fills it.
      for (int i = 0; i < 10; i++) begin disp3(); cycle(); end
      disp3(); cycle();
      chk("drop_free", 256'(free_slots), 256'(2));
      chk("drop_tail", 256'(dispatch_idx[2]), 256'(31));
      disp3(); dispatch_valid = 3'b110; cycle();
      chk("full_flag", 256'(rob_full), 256'(1));
      chk("full_free", 256'(free_slots), 256'(0));
      for (int i = 0; i < 9; i++) begin retire_mask = 3'b111; cycle(); end

      // Reset with count=5 and a dispatch pending.
      reset = 1'b1; disp3(); cycle();
      chk("rst5_empty", 256'(rob_empty), 256'(1));
      chk("rst5_head", 256'(rob_head_entry), 256'(0));

      // Mispredict then flush with retire 2.
      disp3(); cycle();
      complete_valid = 3'b010; complete_idx[1] = 5'd1;
      complete_mispredict = 3'b010; complete_target_pc[1] = 32'h100;
      cycle();
      chk("mp_target", 256'(rob_head_entry[1].target_pc), 256'(32'h100));
      chk("mp_psn", 256'(rob_head_entry[1].precise_state_need), 256'(1));
      retire_mask = 3'b110; BPRecoverEN = 1'b1; disp3();
      complete_valid = 3'b001; complete_idx[0] = 5'd0;
      cycle();
      chk("fl_tail", 256'(dispatch_idx[2]), 256'(2));
      chk("fl_empty", 256'(rob_empty), 256'(1));

      // Port 2 beats port 0 on the same index.
      disp3(); cycle();
      complete_valid = 3'b111; complete_mispredict = 3'b101;
      complete_idx[2] = 5'd3; complete_target_pc[2] = 32'hA0;
      complete_idx[0] = 5'd3; complete_target_pc[0] = 32'hB0;
      complete_idx[1] = 5'd4;
      cycle();
      chk("prio_target", 256'(rob_head_entry[1].target_pc), 256'(32'hA0));

      // Random traffic.
      for (int t = 0; t < 3000; t++) begin
         case ($urandom_range(0, 3))
            0: dispatch_valid = 3'b000;
            1: dispatch_valid = 3'b100;
            2: dispatch_valid = 3'b110;
            default: dispatch_valid = 3'b111;
         endcase
         for (int s = 0; s < 3; s++) dispatch_entry[s] = rand_entry();
         complete_valid      = 3'($urandom);
         complete_mispredict = 3'($urandom);
         for (int k = 0; k < 3; k++) begin
            complete_target_pc[k] = `XLEN'($urandom);
            if (m_cnt > 0 && $urandom_range(0, 3) != 0)
               complete_idx[k] = IDX_W'((m_head + $urandom_range(0, m_cnt - 1)) % N);
            else
               complete_idx[k] = IDX_W'($urandom);
         end
         r = $urandom_range(0, (m_cnt < 3) ? m_cnt : 3);
         retire_mask = (r == 0) ? 3'b000 : (r == 1) ? 3'b100 : (r == 2) ? 3'b110 : 3'b111;
         BPRecoverEN = ($urandom_range(0, 59) == 0);
         reset       = ($urandom_range(0, 299) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
